// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// PC register and next-PC selection: hold, sequential +4, or word-aligned redirect.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4
);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;

    // Redirect wins over sequential advance; the low two bits are always cleared.
    always_comb begin
        pc_next = pc_reg;
        if (redirect) begin
            pc_next = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (advance) begin
            pc_next = pc_reg + XLEN'(PC_INC);
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc  = pc_reg;
    assign pc4 = pc_reg + XLEN'(PC_INC);   // wraps naturally at the top of the address space

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: one outstanding request at a time, redirect with
// in-flight kill. Optional performance counters are enabled by FETCH_PERF_CNT_EN.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hazard_stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            im_req_valid,
    input  logic            im_req_ready,
    output logic [XLEN-1:0] im_req_addr,
    input  logic            im_rsp_valid,
    input  logic [XLEN-1:0] im_rsp_data,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o,
    output logic [XLEN-1:0] inst_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_kill_cnt,
`endif
    output logic            mem_stall_o
);

    fetch_state_e    state_reg, state_next;
    logic            kill_reg, kill_next;
    logic [XLEN-1:0] inst_reg, inst_next;
    logic            advance;
    logic            rsp_drop;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;

    fetch_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (XLEN'(RESET_PC))
    ) u_pc_gen (
        .clk         (clk),
        .rst         (rst),
        .advance     (advance),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .pc4         (pc4)
    );

    // Next-state logic; a redirect in any state moves the PC (handled in fetch_pc_gen)
    // and here decides whether the in-flight or just-accepted fetch must be discarded.
    always_comb begin
        state_next = state_reg;
        kill_next  = kill_reg;
        inst_next  = inst_reg;
        advance    = 1'b0;
        rsp_drop   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (im_req_ready) begin
                    state_next = WAIT;
                    kill_next  = redirect;   // accepted request targets the stale PC
                end
            end
            WAIT: begin
                if (im_rsp_valid) begin
                    if (kill_reg || redirect) begin
                        rsp_drop   = 1'b1;
                        kill_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        inst_next  = im_rsp_data;
                        state_next = DONE;
                    end
                end else if (redirect) begin
                    kill_next = 1'b1;
                end
            end
            DONE: begin
                if (redirect) begin
                    state_next = REQ;
                end else if (!hazard_stall) begin
                    advance    = 1'b1;
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM, kill flag and instruction register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            kill_reg  <= 1'b0;
            inst_reg  <= '0;
        end else begin
            state_reg <= state_next;
            kill_reg  <= kill_next;
            inst_reg  <= inst_next;
        end
    end

    assign im_req_valid = (state_reg == REQ);
    assign im_req_addr  = pc;
    assign pc_o         = pc;
    assign pc4_o        = pc4;
    assign inst_o       = inst_reg;
    assign mem_stall_o  = (state_reg != DONE);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] kill_cnt_reg;

    // Saturating counters for memory stall cycles and discarded responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            kill_cnt_reg  <= '0;
        end else begin
            if (mem_stall_o && (state_reg != IDLE) && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (rsp_drop && (kill_cnt_reg != 32'hFFFF_FFFF)) begin
                kill_cnt_reg <= kill_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_reg;
    assign perf_kill_cnt  = kill_cnt_reg;
`else
    logic unused_drop;
    assign unused_drop = rsp_drop;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit plus hand-written reset/redirect sequences.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        hazard_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        im_req_valid;
    logic        im_req_ready;
    logic [31:0] im_req_addr;
    logic        im_rsp_valid;
    logic [31:0] im_rsp_data;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic [31:0] inst_o;
    logic        mem_stall_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_kill_cnt;
`endif

    int checks = 0;
    int errors = 0;

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .XLEN     (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hazard_stall (hazard_stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .im_req_valid (im_req_valid),
        .im_req_ready (im_req_ready),
        .im_req_addr  (im_req_addr),
        .im_rsp_valid (im_rsp_valid),
        .im_rsp_data  (im_rsp_data),
        .pc_o         (pc_o),
        .pc4_o        (pc4_o),
        .inst_o       (inst_o),
`ifdef FETCH_PERF_CNT_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_kill_cnt  (perf_kill_cnt),
`endif
        .mem_stall_o  (mem_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hz;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        ev;      // expected im_req_valid
        logic [31:0] epc;     // expected pc_o (and im_req_addr)
        logic [31:0] einst;
        logic        es;      // expected mem_stall_o
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic hz, logic rd, logic [31:0] rpc, logic rdy, logic rv,
                                logic [31:0] rdata, logic ev, logic [31:0] epc,
                                logic [31:0] einst, logic es);
        vec_t v;
        v.hz = hz; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
        v.ev = ev; v.epc = epc; v.einst = einst; v.es = es;
        return v;
    endfunction

    task automatic check_outputs(string name, logic ev, logic [31:0] epc, logic [31:0] einst,
                                 logic es);
        logic [31:0] epc4;
        epc4 = epc + 32'd4;
        checks++;
        if (im_req_valid !== ev || im_req_addr !== epc || pc_o !== epc || pc4_o !== epc4 ||
            inst_o !== einst || mem_stall_o !== es) begin
            errors++;
            $display("FAIL %s: got valid=%0b addr=%h pc=%h pc4=%h inst=%h stall=%0b; want valid=%0b addr=%h pc=%h pc4=%h inst=%h stall=%0b",
                     name, im_req_valid, im_req_addr, pc_o, pc4_o, inst_o, mem_stall_o,
                     ev, epc, epc, epc4, einst, es);
        end else begin
            $display("%s ok: valid=%0b addr=%h pc=%h inst=%h stall=%0b",
                     name, im_req_valid, im_req_addr, pc_o, inst_o, mem_stall_o);
        end
    endtask

    task automatic drive_idle();
        hazard_stall = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        im_req_ready = 1'b1;
        im_rsp_valid = 1'b0;
        im_rsp_data  = 32'h0;
    endtask

    initial begin
        logic [31:0] I1;
        logic [31:0] I2;
        bit          seen;
        I1 = 32'h0000_0013;
        I2 = 32'h0050_0093;

        // hz rd rpc rdy rv rdata | ev pc inst stall
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,            0,32'h0,32'h0,1));  // 0 IDLE
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,            1,32'h0,32'h0,1));  // 1 REQ @0
        vecs.push_back(mk(0,0,32'h0,1,1,I1,               0,32'h0,32'h0,1));  // 2 WAIT rsp
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,            0,32'h0,I1,0));     // 3 DONE pc0
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,            1,32'h4,I1,1));     // 4 REQ @4
        vecs.push_back(mk(0,0,32'h0,1,1,I1,               0,32'h4,I1,1));     // 5
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,            0,32'h4,I1,0));     // 6 DONE pc4
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,            1,32'h8,I1,1));     // 7 REQ @8
        vecs.push_back(mk(0,0,32'h0,1,1,I1,               0,32'h8,I1,1));     // 8
        vecs.push_back(mk(1,0,32'h0,1,0,32'h0,            0,32'h8,I1,0));     // 9 hazard
        vecs.push_back(mk(1,0,32'h0,1,1,32'hCCCC_0003,    0,32'h8,I1,0));     // 10 hazard, stray rsp
        vecs.push_back(mk(1,0,32'h0,1,0,32'h0,            0,32'h8,I1,0));     // 11 hazard
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,            0,32'h8,I1,0));     // 12 release
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,            1,32'hC,I1,1));     // 13 REQ @C
        vecs.push_back(mk(0,1,32'h100,1,0,32'h0,          0,32'hC,I1,1));     // 14 redirect in WAIT
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,            0,32'h100,I1,1));   // 15
        vecs.push_back(mk(0,0,32'h0,1,1,32'hDEAD_BEEF,    0,32'h100,I1,1));   // 16 killed rsp
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,            1,32'h100,I1,1));   // 17 REQ @100
        vecs.push_back(mk(0,0,32'h0,1,1,I2,               0,32'h100,I1,1));   // 18
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,            0,32'h100,I2,0));   // 19 DONE
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,            1,32'h104,I2,1));   // 20 REQ @104
        vecs.push_back(mk(0,1,32'h40,1,1,32'hAAAA_0001,   0,32'h104,I2,1));   // 21 redirect + rsp
        vecs.push_back(mk(0,1,32'h80,1,0,32'h0,           1,32'h40,I2,1));    // 22 redirect + accept
        vecs.push_back(mk(0,0,32'h0,1,1,32'hBBBB_0002,    0,32'h80,I2,1));    // 23 killed rsp
        vecs.push_back(mk(0,0,32'h0,0,1,32'h1111_1111,    1,32'h80,I2,1));    // 24 ready low, stray rsp
        vecs.push_back(mk(0,0,32'h0,0,0,32'h0,            1,32'h80,I2,1));    // 25
        vecs.push_back(mk(0,1,32'h203,0,0,32'h0,          1,32'h80,I2,1));    // 26 redirect unaligned
        vecs.push_back(mk(0,0,32'h0,0,0,32'h0,            1,32'h200,I2,1));   // 27
        vecs.push_back(mk(0,0,32'h0,0,0,32'h0,            1,32'h200,I2,1));   // 28
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,            1,32'h200,I2,1));   // 29 accept
        vecs.push_back(mk(0,0,32'h0,1,1,I1,               0,32'h200,I2,1));   // 30
        vecs.push_back(mk(0,1,32'hFFFF_FFFC,1,0,32'h0,    0,32'h200,I1,0));   // 31 redirect in DONE
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,            1,32'hFFFF_FFFC,I1,1)); // 32
        vecs.push_back(mk(0,0,32'h0,1,1,32'h0000_0033,    0,32'hFFFF_FFFC,I1,1)); // 33
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,            0,32'hFFFF_FFFC,32'h33,0)); // 34 pc4 wraps
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,            1,32'h0,32'h33,1)); // 35 REQ @0

        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 32'h0, 32'h0, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            hazard_stall = vecs[i].hz;
            redirect     = vecs[i].rd;
            redirect_pc  = vecs[i].rpc;
            im_req_ready = vecs[i].rdy;
            im_rsp_valid = vecs[i].rv;
            im_rsp_data  = vecs[i].rdata;
            @(negedge clk);
            check_outputs($sformatf("row%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].einst, vecs[i].es);
            @(posedge clk);
            #1;
        end

        // Reset asserted while a fetch is outstanding (state WAIT after the last row).
        drive_idle();
        rst = 1'b1;
        #1;
        check_outputs("midreset", 1'b0, 32'h0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Redirect while in IDLE: first request goes to the aligned redirect target.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0305;
        @(posedge clk);
        #1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        im_req_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            if (im_req_valid) seen = 1'b1;
            else @(posedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL idle_redirect_timeout: got no im_req_valid within 5 cycles, want a request");
        end else begin
            check_outputs("idle_redirect", 1'b1, 32'h304, 32'h0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
